dsp48a1_mac_sched: RTL and testbench

- Sequencer that runs one DSP48A1 slice (default pipeline: A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0/B0=0) as a signed multiply-accumulate engine.
- Accepts a job of cfg_len operand pairs over a valid/ready stream.
- Drives the slice's A/B, OPMODE, CE and reset pins with pipeline-aligned control, waits for the pipeline to drain, and returns sum(A*B) on a result handshake.

---
 rtl/dsp48a1_pkg.sv | 35 +++
 rtl/dsp48a1_mac_sched_if.sv | 25 ++
 rtl/dsp48a1_align_pipe.sv | 33 +++
 rtl/dsp48a1_mac_sched.sv | 144 ++++++++++++++
 tb/tb_dsp48a1_mac_sched.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 MAC scheduler: OPMODE fields, widths, FSM states.
// DSP_ROUND_EN selects a C-port rounding term for the first product of a job.
package dsp48a1_pkg;

  localparam int A_W = 18;
  localparam int P_W = 48;

  // X mux select, OPMODE[1:0]
  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_DAB  = 2'b11;

  // Z mux select, OPMODE[3:2]
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_PCIN = 2'b01;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

`ifdef DSP_ROUND_EN
  localparam logic [7:0] OPM_FIRST = {4'b0000, Z_C, X_M};
`else
  localparam logic [7:0] OPM_FIRST = {4'b0000, Z_ZERO, X_M};
`endif
  localparam logic [7:0] OPM_ACC = {4'b0000, Z_P, X_M};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/dsp48a1_mac_sched_if.sv
// Host-side job, operand-stream and result handshake for the DSP48A1 MAC scheduler.
interface dsp48a1_mac_sched_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [17:0]      s_a;
  logic [17:0]      s_b;
  logic             m_valid;
  logic             m_ready;
  logic [47:0]      m_result;

  modport master (
    output start, cfg_len, s_valid, s_a, s_b, m_ready,
    input  busy, s_ready, m_valid, m_result
  );

  modport slave (
    input  start, cfg_len, s_valid, s_a, s_b, m_ready,
    output busy, s_ready, m_valid, m_result
  );
endinterface

// File: rtl/dsp48a1_align_pipe.sv
// Delays each operand issue so OPMODE lands one cycle and CEP two cycles after it,
// matching the slice's A1/B1 -> M -> P register chain.
module dsp48a1_align_pipe
  import dsp48a1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       issue,
  input  logic       first,
  output logic [7:0] opmode,
  output logic       cep
);

  logic [DEPTH-1:0] issue_sr_r;
  logic [7:0]       opmode_r;

  // Issue shift register; the first-term flag only matters at stage 0, where OPMODE is chosen.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      issue_sr_r <= {DEPTH{1'b0}};
      opmode_r   <= 8'h00;
    end else begin
      issue_sr_r <= {issue_sr_r[DEPTH-2:0], issue};
      opmode_r   <= (issue && first) ? OPM_FIRST : OPM_ACC;
    end
  end

  assign opmode = opmode_r;
  assign cep    = issue_sr_r[DEPTH-1];

endmodule

// File: rtl/dsp48a1_mac_sched.sv
// Runs a DSP48A1 slice as a signed MAC: clears it, feeds cfg_len pairs, drains, returns P.
// Optional DSP_ROUND_EN adds ROUND_CONST through the C port on the first term.
module dsp48a1_mac_sched
  import dsp48a1_pkg::*;
#(
  parameter int             LEN_W       = 8,
  parameter int             PIPE_LAT    = 3,
  parameter logic [P_W-1:0] ROUND_CONST = 48'h0000_0002_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  dsp48a1_mac_sched_if.slave    bus,
  output logic [A_W-1:0]        dsp_a,
  output logic [A_W-1:0]        dsp_b,
  output logic [P_W-1:0]        dsp_c,
  output logic [7:0]            dsp_opmode,
  output logic                  dsp_cea,
  output logic                  dsp_ceb,
  output logic                  dsp_cep,
  output logic                  dsp_cem,
  output logic                  dsp_ceopmode,
  output logic                  dsp_rst,
  input  logic [P_W-1:0]        dsp_p
);

  localparam int DW = $clog2(PIPE_LAT) + 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT - 1);
`ifdef DSP_ROUND_EN
  localparam logic ROUND_ON = 1'b1;
`else
  localparam logic ROUND_ON = 1'b0;
`endif
  localparam logic [P_W-1:0] C_CONST = ROUND_ON ? ROUND_CONST : {P_W{1'b0}};

  state_t           state_r;
  logic [LEN_W-1:0] remaining_r;
  logic [DW-1:0]    drain_cnt_r;
  logic             first_r;
  logic             s_ready_r;
  logic             busy_r;
  logic             m_valid_r;
  logic [P_W-1:0]   m_result_r;
  logic             dsp_rst_r;
  logic             issue_s;

  assign issue_s = bus.s_valid & s_ready_r;

  // Job sequencer: CLR pulses the slice reset, FEED counts issues, DRAIN waits out the pipeline.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      remaining_r <= {LEN_W{1'b0}};
      drain_cnt_r <= {DW{1'b0}};
      first_r     <= 1'b0;
      s_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      m_valid_r   <= 1'b0;
      m_result_r  <= {P_W{1'b0}};
      dsp_rst_r   <= 1'b0;
    end else begin
      dsp_rst_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r     <= CLR;
            remaining_r <= bus.cfg_len;
            first_r     <= 1'b1;
            busy_r      <= 1'b1;
            dsp_rst_r   <= 1'b1;
          end
        end
        CLR: begin
          if (remaining_r == {LEN_W{1'b0}}) begin
            state_r    <= RESULT;
            m_valid_r  <= 1'b1;
            m_result_r <= C_CONST;
          end else begin
            state_r   <= FEED;
            s_ready_r <= 1'b1;
          end
        end
        FEED: begin
          if (issue_s) begin
            remaining_r <= remaining_r - LEN_W'(1);
            first_r     <= 1'b0;
            if (remaining_r == LEN_W'(1)) begin
              state_r     <= DRAIN;
              s_ready_r   <= 1'b0;
              drain_cnt_r <= DRAIN_INIT;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_r == {DW{1'b0}}) begin
            state_r    <= RESULT;
            m_valid_r  <= 1'b1;
            m_result_r <= dsp_p;
          end else begin
            drain_cnt_r <= drain_cnt_r - DW'(1);
          end
        end
        RESULT: begin
          if (bus.m_ready) begin
            state_r   <= IDLE;
            m_valid_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          s_ready_r <= 1'b0;
          m_valid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  dsp48a1_align_pipe #(
    .DEPTH (PIPE_LAT - 1)
  ) u_align (
    .CLK    (CLK),
    .RST    (RST),
    .issue  (issue_s),
    .first  (first_r),
    .opmode (dsp_opmode),
    .cep    (dsp_cep)
  );

  assign bus.busy     = busy_r;
  assign bus.s_ready  = s_ready_r;
  assign bus.m_valid  = m_valid_r;
  assign bus.m_result = m_result_r;

  assign dsp_a        = bus.s_a;
  assign dsp_b        = bus.s_b;
  assign dsp_c        = C_CONST;
  assign dsp_cea      = issue_s;
  assign dsp_ceb      = issue_s;
  assign dsp_cem      = 1'b1;
  assign dsp_ceopmode = 1'b1;
  assign dsp_rst      = dsp_rst_r;

endmodule

// File: tb/tb_dsp48a1_mac_sched.sv
// Directed bench for dsp48a1_mac_sched with a behavioural DSP48A1 slice (A1/B1/M/P/OPMODE regs).
module tb_dsp48a1_mac_sched;

`ifdef DSP_ROUND_EN
  localparam logic [47:0] OFF = 48'h0000_0002_0000;
`else
  localparam logic [47:0] OFF = 48'h0000_0000_0000;
`endif

  logic        CLK;
  logic        RST;
  logic [17:0] dsp_a, dsp_b;
  logic [47:0] dsp_c;
  logic [7:0]  dsp_opmode;
  logic        dsp_cea, dsp_ceb, dsp_cep, dsp_cem, dsp_ceopmode, dsp_rst;
  logic [47:0] dsp_p;

  int n_checks = 0;
  int n_fail   = 0;
  int cep_cnt  = 0;

  dsp48a1_mac_sched_if #(.LEN_W(8)) bus ();

  dsp48a1_mac_sched dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_c        (dsp_c),
    .dsp_opmode   (dsp_opmode),
    .dsp_cea      (dsp_cea),
    .dsp_ceb      (dsp_ceb),
    .dsp_cep      (dsp_cep),
    .dsp_cem      (dsp_cem),
    .dsp_ceopmode (dsp_ceopmode),
    .dsp_rst      (dsp_rst),
    .dsp_p        (dsp_p)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Slice model: synchronous reset from dsp_rst, X/Z post-adder muxes.
  logic signed [17:0] a1_r, b1_r;
  logic signed [35:0] prod_s;
  logic [47:0]        m_r, p_r, x_s, z_s;
  logic [7:0]         opm_r;

  assign prod_s = a1_r * b1_r;
  assign dsp_p  = p_r;

  always_comb begin
    case (opm_r[1:0])
      2'b01:   x_s = m_r;
      2'b10:   x_s = p_r;
      default: x_s = 48'd0;
    endcase
    case (opm_r[3:2])
      2'b10:   z_s = p_r;
      2'b11:   z_s = dsp_c;
      default: z_s = 48'd0;
    endcase
  end

  always @(posedge CLK) begin
    if (dsp_rst) begin
      a1_r  <= 18'sd0;
      b1_r  <= 18'sd0;
      m_r   <= 48'd0;
      p_r   <= 48'd0;
      opm_r <= 8'd0;
    end else begin
      if (dsp_cea) a1_r <= dsp_a;
      if (dsp_ceb) b1_r <= dsp_b;
      if (dsp_cem) m_r <= {{12{prod_s[35]}}, prod_s};
      if (dsp_ceopmode) opm_r <= dsp_opmode;
      if (dsp_cep) p_r <= x_s + z_s;
    end
  end

  always @(negedge CLK) begin
    if (dsp_cep) cep_cnt <= cep_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_job(input int len);
    bus.start   = 1'b1;
    bus.cfg_len = 8'(len);
    tick();
    bus.start = 1'b0;
    check_eq("clr_rst", {63'd0, dsp_rst}, 64'd1);
    check_eq("clr_busy", {63'd0, bus.busy}, 64'd1);
    tick();
    check_eq("rst_1cyc", {63'd0, dsp_rst}, 64'd0);
    check_eq("rdy_after_clr", {63'd0, bus.s_ready}, {63'd0, len != 0});
  endtask

  task automatic send(input int a, input int b);
    check_eq("s_ready", {63'd0, bus.s_ready}, 64'd1);
    bus.s_valid = 1'b1;
    bus.s_a     = 18'(a);
    bus.s_b     = 18'(b);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.m_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("m_valid", {63'd0, bus.m_valid}, 64'd1);
  endtask

  task automatic ack();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check_eq("mv_drop", {63'd0, bus.m_valid}, 64'd0);
    check_eq("idle_busy", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int lat;
    int cep0;
    RST         = 1'b1;
    bus.start   = 1'b0;
    bus.cfg_len = 8'd0;
    bus.s_valid = 1'b0;
    bus.s_a     = 18'd0;
    bus.s_b     = 18'd0;
    bus.m_ready = 1'b0;
    #1;
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_sready", {63'd0, bus.s_ready}, 64'd0);
    check_eq("rst_mvalid", {63'd0, bus.m_valid}, 64'd0);
    check_eq("rst_result", {16'd0, bus.m_result}, 64'd0);
    check_eq("rst_opmode", {56'd0, dsp_opmode}, 64'd0);
    check_eq("rst_ce", {60'd0, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rst}, 64'b1100);
    tick();
    tick();
    RST = 1'b0;
    tick();

    // 1: back-to-back pairs, exact result latency
    start_job(3);
    send(2, 3);
    send(4, 5);
    send(-1, 6);
    wait_res(lat);
    check_eq("t1_lat", 64'(lat), 64'd3);
    check_eq("t1_res", {16'd0, bus.m_result}, {16'd0, 48'd20 + OFF});
    ack();

    // 2: bubbles between operands, CEP pulse count
    cep0 = cep_cnt;
    start_job(2);
    send(-7, 100);
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_bubble_rdy", {63'd0, bus.s_ready}, 64'd1);
      tick();
    end
    send(1000, 1000);
    wait_res(lat);
    check_eq("t2_lat", 64'(lat), 64'd3);
    check_eq("t2_res", {16'd0, bus.m_result}, {16'd0, 48'd999300 + OFF});
    check_eq("t2_cep", 64'(cep_cnt - cep0), 64'd2);
    ack();

    // 3: empty job
    start_job(0);
    wait_res(lat);
    check_eq("t3_lat", 64'(lat), 64'd0);
    check_eq("t3_res", {16'd0, bus.m_result}, {16'd0, OFF});
    ack();

    // 4: backpressure on the result, start ignored while busy
    start_job(1);
    send(5, 7);
    wait_res(lat);
    for (int i = 0; i < 5; i++) begin
      bus.start   = (i % 2 == 0);
      bus.cfg_len = 8'd9;
      tick();
      check_eq("t4_hold_res", {16'd0, bus.m_result}, {16'd0, 48'd35 + OFF});
      check_eq("t4_hold_mv", {62'd0, bus.m_valid, bus.busy}, 64'b11);
    end
    bus.start = 1'b0;
    ack();
    tick();
    check_eq("t4_no_job", {62'd0, bus.busy, dsp_rst}, 64'd0);

    // 5: abort mid-job, then a clean job
    start_job(4);
    send(10, 10);
    bus.s_valid = 1'b1;
    bus.s_a     = 18'd20;
    bus.s_b     = 18'd20;
    tick();
    RST = 1'b1;
    #1;
    check_eq("t5_abort", {58'd0, bus.busy, bus.s_ready, bus.m_valid, dsp_cea, dsp_cep, dsp_rst}, 64'd0);
    check_eq("t5_opm", {56'd0, dsp_opmode}, 64'd0);
    bus.s_valid = 1'b0;
    #2;
    RST = 1'b0;
    tick();
    start_job(1);
    send(3, 3);
    wait_res(lat);
    check_eq("t5_res", {16'd0, bus.m_result}, {16'd0, 48'd9 + OFF});
    ack();

    // 6: operand extremes
    start_job(1);
    send(-131072, -131072);
    wait_res(lat);
    check_eq("t6_maxpos", {16'd0, bus.m_result}, {16'd0, 48'd17179869184 + OFF});
    ack();
    start_job(1);
    send(131071, -131072);
    wait_res(lat);
    check_eq("t6_neg", {16'd0, bus.m_result}, {16'd0, 48'hFFFC_0002_0000 + OFF});
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
